// File: rtl/mc_pkg.sv
// Shared types for the multicycle ARM control decoder: FSM states, ALU op codes, Op field values.
package mc_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned ALU_OP_W = 3;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        MULX   = 4'd10
    } state_t;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_ORR = 3'd3,
        ALU_EOR = 3'd4,
        ALU_MUL = 3'd5
    } alu_op_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/mc_decode_alu_dec.sv
// Data-processing command decoder: maps Funct[4:1] to an ALU op and flag-write enables.
module alu_dec
    import mc_pkg::*;
(
    input  logic [4:0]          Funct,
    input  logic                active,
    output alu_op_t             ALUControl,
    output logic [1:0]          FlagW,
    output logic                NoWrite,
    output logic                Illegal
);

    alu_op_t op;
    logic    legal;
    logic    cmp;

    always_comb begin
        op    = ALU_ADD;
        legal = 1'b1;
        cmp   = 1'b0;
        case (Funct[4:1])
            4'b0100: op = ALU_ADD;
            4'b0010: op = ALU_SUB;
            4'b0000: op = ALU_AND;
            4'b1100: op = ALU_ORR;
            4'b0001: op = ALU_EOR;
            4'b1010: begin
                op  = ALU_SUB;
                cmp = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        Illegal    = ~legal;
        NoWrite    = cmp;
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        if (active && legal) begin
            ALUControl = op;
            // CMP always updates all flags; otherwise the S bit decides, C/V only for add/sub
            if (cmp) FlagW = 2'b11;
            else     FlagW = {Funct[0], Funct[0] & ((op == ALU_ADD) | (op == ALU_SUB))};
        end
    end

endmodule

// File: rtl/mc_decode.sv
// Multicycle ARM control FSM (Moore) with ALU decode; optional multi-cycle multiply under `MUL_EN.
// Outputs are combinational from the current state plus Op/Funct/Rd.
module mc_decode
    import mc_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned MUL_LAT   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 IsMul,
    output logic                 PCS,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 NextPC,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [1:0]           FlagW,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Illegal,
    output logic [3:0]           State
);

    state_t     state, next_state;
    alu_op_t    dec_op;
    logic [1:0] dec_flag_w;
    logic       dec_no_write;
    logic       dec_illegal;
    logic       dec_active;
    logic       mul_route;
    logic       mul_first;
    logic       mul_done;
    logic       reg_w;
    logic       branch;
    alu_op_t    alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    assign dec_active = (state == EXECR) | (state == EXECI) | (state == ALUWB);

    alu_dec u_alu_dec (
        .Funct      (Funct[4:0]),
        .active     (dec_active),
        .ALUControl (dec_op),
        .FlagW      (dec_flag_w),
        .NoWrite    (dec_no_write),
        .Illegal    (dec_illegal)
    );

`ifdef MUL_EN
    logic [3:0] mul_cnt;

    // Latency counter: loaded on DECODE->MULX, counts down to zero while in MULX
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                         mul_cnt <= 4'd0;
        else if (state == DECODE && next_state == MULX)    mul_cnt <= 4'(MUL_LAT - 1);
        else if (state == MULX && mul_cnt != 4'd0)         mul_cnt <= mul_cnt - 4'd1;
    end

    assign mul_route = IsMul;
    assign mul_first = (mul_cnt == 4'(MUL_LAT - 1));
    assign mul_done  = (mul_cnt == 4'd0);
`else
    logic [4:0] unused_mul;
    assign unused_mul = {IsMul, 4'(MUL_LAT)};
    assign mul_route  = 1'b0;
    assign mul_first  = 1'b0;
    assign mul_done   = 1'b0;
`endif

    always_comb begin
        next_state = state;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        FlagW      = 2'b00;
        MemW       = 1'b0;
        Illegal    = 1'b0;
        reg_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = ALU_ADD;

        case (state)
            FETCH: begin
                IRWrite    = 1'b1;
                NextPC     = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                next_state = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    OP_MEM: next_state = MEMADR;
                    OP_BR:  next_state = BRANCH;
                    OP_DP: begin
                        if (mul_route) next_state = MULX;
                        else if (dec_illegal) begin
                            next_state = FETCH;
                            Illegal    = 1'b1;
                        end
                        else if (Funct[5]) next_state = EXECI;
                        else               next_state = EXECR;
                    end
                    default: begin
                        next_state = FETCH;
                        Illegal    = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                next_state = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc     = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                reg_w      = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                AdrSrc     = 1'b1;
                MemW       = 1'b1;
                next_state = FETCH;
            end
            EXECR: begin
                alu_op     = dec_op;
                FlagW      = dec_flag_w;
                next_state = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                alu_op     = dec_op;
                FlagW      = dec_flag_w;
                next_state = ALUWB;
            end
            ALUWB: begin
                alu_op     = dec_op;
                reg_w      = ~dec_no_write;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                branch     = 1'b1;
                next_state = FETCH;
            end
            MULX: begin
                alu_op = ALU_MUL;
                FlagW  = (mul_first && Funct[0]) ? 2'b10 : 2'b00;
                if (mul_done) next_state = ALUWB;
            end
            default: next_state = FETCH;
        endcase
    end

    assign RegW       = reg_w;
    assign PCS        = (reg_w & (Rd == 4'hF)) | branch;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == OP_MEM, Op == OP_BR};
    assign ALUControl = ALUCTRL_W'(alu_op);
    assign State      = state;

endmodule

// File: tb/tb_mc_decode.sv
// Scoreboard bench for mc_decode: an instruction-level model queues the expected per-cycle
// control trace; a negedge monitor pops and compares every cycle.
module tb_mc_decode;
    import mc_pkg::*;

    localparam int unsigned MUL_LAT = 4;
`ifdef MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IsMul;
    logic       PCS, RegW, MemW, NextPC, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW;
    logic [2:0] ALUControl;
    logic       Illegal;
    logic [3:0] State;

    typedef struct packed {
        logic [3:0] st;
        logic       pcs, regw, memw, nextpc, irwrite, adrsrc, alusrca;
        logic [1:0] resultsrc, alusrcb, immsrc, regsrc, flagw;
        logic [2:0] aluc;
        logic       illegal;
    } rec_t;

    rec_t       exp_q[$];
    rec_t       mon_act, mon_exp;
    int         checks = 0;
    int         passed = 0;
    bit         mon_en = 1'b0;
    string      cur_tag = "none";
    logic [3:0] legal_codes [6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010};

    always #5 clk = ~clk;

    mc_decode #(.ALUCTRL_W(3), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .IsMul(IsMul),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NextPC(NextPC), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .FlagW(FlagW), .ALUControl(ALUControl),
        .Illegal(Illegal), .State(State)
    );

    function automatic rec_t sample();
        rec_t r;
        r = '{st: State, pcs: PCS, regw: RegW, memw: MemW, nextpc: NextPC, irwrite: IRWrite,
              adrsrc: AdrSrc, alusrca: ALUSrcA, resultsrc: ResultSrc, alusrcb: ALUSrcB,
              immsrc: ImmSrc, regsrc: RegSrc, flagw: FlagW, aluc: ALUControl, illegal: Illegal};
        return r;
    endfunction

    function automatic rec_t blank(input logic [1:0] op, input state_t st);
        rec_t r;
        r        = '0;
        r.st     = st;
        r.immsrc = op;
        r.regsrc = {op == 2'b01, op == 2'b10};
        return r;
    endfunction

    function automatic rec_t fetch_rec(input logic [1:0] op);
        rec_t r;
        r           = blank(op, FETCH);
        r.irwrite   = 1'b1;
        r.nextpc    = 1'b1;
        r.alusrca   = 1'b1;
        r.alusrcb   = 2'b10;
        r.resultsrc = 2'b10;
        return r;
    endfunction

    // ADD=0 SUB=1 AND=2 ORR=3 EOR=4; CMP behaves as SUB without write-back
    function automatic void alu_table(input logic [3:0] c, output int code, output bit legal,
                                      output bit cmp);
        legal = 1'b1;
        cmp   = 1'b0;
        code  = 0;
        case (c)
            4'b0100: code = 0;
            4'b0010: code = 1;
            4'b0000: code = 2;
            4'b1100: code = 3;
            4'b0001: code = 4;
            4'b1010: begin code = 1; cmp = 1'b1; end
            default: legal = 1'b0;
        endcase
    endfunction

    // Expected control trace of one instruction, FETCH through last state
    function automatic int model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [3:0] rd, input logic im);
        rec_t r;
        int   code, n;
        bit   legal, cmp, is_mul;
        n = 0;
        alu_table(f[4:1], code, legal, cmp);
        is_mul = (op == 2'b00) && im && MUL_ON;

        exp_q.push_back(fetch_rec(op)); n++;
        r           = blank(op, DECODE);
        r.alusrca   = 1'b1;
        r.alusrcb   = 2'b10;
        r.resultsrc = 2'b10;
        r.illegal   = (op == 2'b11) || (op == 2'b00 && !is_mul && !legal);
        exp_q.push_back(r); n++;
        if (r.illegal) return n;

        if (op == 2'b01) begin
            r = blank(op, MEMADR); r.alusrcb = 2'b01;
            exp_q.push_back(r); n++;
            if (f[0]) begin
                r = blank(op, MEMRD); r.adrsrc = 1'b1;
                exp_q.push_back(r); n++;
                r = blank(op, MEMWB); r.resultsrc = 2'b01; r.regw = 1'b1; r.pcs = (rd == 4'hF);
                exp_q.push_back(r); n++;
            end else begin
                r = blank(op, MEMWR); r.adrsrc = 1'b1; r.memw = 1'b1;
                exp_q.push_back(r); n++;
            end
        end else if (op == 2'b10) begin
            r = blank(op, BRANCH); r.alusrcb = 2'b01; r.resultsrc = 2'b10; r.pcs = 1'b1;
            exp_q.push_back(r); n++;
        end else begin
            if (is_mul) begin
                for (int i = 0; i < int'(MUL_LAT); i++) begin
                    r = blank(op, MULX); r.aluc = 3'd5;
                    r.flagw = (i == 0 && f[0]) ? 2'b10 : 2'b00;
                    exp_q.push_back(r); n++;
                end
            end else begin
                r = blank(op, f[5] ? EXECI : EXECR);
                r.alusrcb = f[5] ? 2'b01 : 2'b00;
                r.aluc    = 3'(code);
                r.flagw   = cmp ? 2'b11 : {f[0], f[0] & (code == 0 || code == 1)};
                exp_q.push_back(r); n++;
            end
            r      = blank(op, ALUWB);
            r.aluc = legal ? 3'(code) : 3'd0;
            r.regw = !cmp;
            r.pcs  = !cmp && (rd == 4'hF);
            exp_q.push_back(r); n++;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // Called just after the edge that enters FETCH; returns just after the next FETCH edge
    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                         input logic im, input string tag);
        int n;
        cur_tag = tag;
        Op      = op;
        Funct   = f;
        Rd      = rd;
        IsMul   = im;
        n       = model(op, f, rd, im);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_act = sample();
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL trace[%s]: got unexpected cycle %h want nothing queued", cur_tag, mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act === mon_exp) passed++;
                else $display("FAIL trace[%s]: got %h want %h", cur_tag, mon_act, mon_exp);
            end
        end
    end

    initial begin
        reset = 1'b1;
        Op    = 2'b00;
        Funct = 6'd0;
        Rd    = 4'd0;
        IsMul = 1'b0;
        @(negedge clk);
        chk("reset_fetch", 32'(sample()), 32'(fetch_rec(Op)));
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        issue(2'b01, 6'b011001, 4'hF, 1'b0, "LDR_pc");
        issue(2'b01, 6'b011001, 4'h4, 1'b0, "LDR");
        issue(2'b00, 6'b001001, 4'h2, 1'b0, "ADDS");
        issue(2'b00, 6'b110101, 4'h3, 1'b0, "CMP_imm");
        issue(2'b00, 6'b000010, 4'h4, 1'b0, "EOR");
        issue(2'b10, 6'b101010, 4'h0, 1'b0, "B");
        issue(2'b11, 6'b000000, 4'h1, 1'b0, "op11");
        issue(2'b00, 6'b000001, 4'h5, 1'b1, "MUL");
        issue(2'b00, 6'b011110, 4'h6, 1'b0, "bad_alu");
        issue(2'b00, 6'b001000, 4'hF, 1'b0, "ADD_pc");
        issue(2'b00, 6'b111001, 4'h7, 1'b0, "ORRS_imm");

        // Reset while the store is in MEMWR
        mon_en  = 1'b0;
        cur_tag = "STR_reset";
        Op      = 2'b01;
        Funct   = 6'b011000;
        Rd      = 4'h3;
        IsMul   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("memwr_state", 32'(State), 32'(MEMWR));
        chk("memwr_memw", 32'(MemW), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_memw", 32'(MemW), 32'd0);
        chk("rst_state", 32'(State), 32'(FETCH));
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_rst_fetch", 32'(sample()), 32'(fetch_rec(Op)));
        mon_en = 1'b1;

        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            logic [5:0] f;
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom);
            if ($urandom_range(0, 3) != 0) f[4:1] = legal_codes[$urandom_range(0, 5)];
            issue(op, f, 4'($urandom), 1'($urandom), "rand");
        end

        mon_en = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
